// File: rtl/fp32_mul_round_stage_if.sv
// Handshake and payload bundle between the FP32 multiplier core and its round stage.
// master drives the product and consumes the result; slave is the round stage itself.
interface fp32_mul_round_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic        in_is_nan;
    logic        in_is_inf;
    logic        in_is_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_is_nan, in_is_inf, in_is_zero, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_is_nan, in_is_inf, in_is_zero, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
    );
endinterface

// File: rtl/fp32_mul_round_stage.sv
// FP32 multiplier back end: S1 normalizes the 48-bit product, S2 rounds to nearest-even
// and classifies specials/overflow/underflow. Elastic two-stage valid/ready pipeline.
module fp32_mul_round_stage #(
    parameter logic [31:0] QNAN = 32'h7FC0_0000,
    parameter int          FTZ  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fp32_mul_round_stage_if.slave io
);

    logic               r_s1_valid;
    logic               r_s1_sign;
    logic signed [9:0]  r_s1_exp;
    logic [22:0]        r_s1_frac;
    logic               r_s1_g;
    logic               r_s1_s;
    logic               r_s1_nan;
    logic               r_s1_inf;
    logic               r_s1_zero;

    logic               r_s2_valid;
    logic [31:0]        r_s2_result;
    logic               r_s2_overflow;
    logic               r_s2_underflow;
    logic               r_s2_inexact;

    logic               w_s2_load;
    logic               w_s1_load;

    logic signed [9:0]  w_n_exp;
    logic [22:0]        w_n_frac;
    logic               w_n_g;
    logic               w_n_s;

    logic               w_round_up;
    logic [23:0]        w_frac_sum;
    logic signed [9:0]  w_r_exp;
    logic [31:0]        w_result;
    logic               w_overflow;
    logic               w_underflow;
    logic               w_inexact;

    // Ready propagates backwards combinationally so bubbles collapse; valid only moves through flops.
    assign w_s2_load   = !r_s2_valid || io.out_ready;
    assign w_s1_load   = !r_s1_valid || w_s2_load;
    assign io.in_ready = w_s1_load;

    always_comb begin
        if (io.in_mant[47]) begin
            w_n_exp  = $signed(io.in_exp) + 10'sd1;
            w_n_frac = io.in_mant[46:24];
            w_n_g    = io.in_mant[23];
            w_n_s    = |io.in_mant[22:0];
        end else begin
            w_n_exp  = $signed(io.in_exp);
            w_n_frac = io.in_mant[45:23];
            w_n_g    = io.in_mant[22];
            w_n_s    = |io.in_mant[21:0];
        end
    end

    assign w_round_up = r_s1_g && (r_s1_s || r_s1_frac[0]);
    assign w_frac_sum = {1'b0, r_s1_frac} + {23'd0, w_round_up};
    assign w_r_exp    = w_frac_sum[23] ? (r_s1_exp + 10'sd1) : r_s1_exp;

    // Range checks use the full signed 10-bit rounded exponent, never the 8-bit field.
    always_comb begin
        w_result    = {r_s1_sign, w_r_exp[7:0], w_frac_sum[22:0]};
        w_overflow  = 1'b0;
        w_underflow = 1'b0;
        w_inexact   = r_s1_g || r_s1_s;
        if (r_s1_nan) begin
            w_result  = QNAN;
            w_inexact = 1'b0;
        end else if (r_s1_inf) begin
            w_result  = {r_s1_sign, 8'hFF, 23'd0};
            w_inexact = 1'b0;
        end else if (r_s1_zero) begin
            w_result  = {r_s1_sign, 31'd0};
            w_inexact = 1'b0;
        end else if (w_r_exp >= 10'sd255) begin
            w_result   = {r_s1_sign, 8'hFF, 23'd0};
            w_overflow = 1'b1;
            w_inexact  = 1'b1;
        end else if ((FTZ != 0) && (w_r_exp <= 10'sd0)) begin
            w_result    = {r_s1_sign, 31'd0};
            w_underflow = 1'b1;
            w_inexact   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid     <= 1'b0;
            r_s1_sign      <= 1'b0;
            r_s1_exp       <= '0;
            r_s1_frac      <= '0;
            r_s1_g         <= 1'b0;
            r_s1_s         <= 1'b0;
            r_s1_nan       <= 1'b0;
            r_s1_inf       <= 1'b0;
            r_s1_zero      <= 1'b0;
            r_s2_valid     <= 1'b0;
            r_s2_result    <= '0;
            r_s2_overflow  <= 1'b0;
            r_s2_underflow <= 1'b0;
            r_s2_inexact   <= 1'b0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= io.in_valid;
            end
            if (w_s1_load && io.in_valid) begin
                r_s1_sign <= io.in_sign;
                r_s1_exp  <= w_n_exp;
                r_s1_frac <= w_n_frac;
                r_s1_g    <= w_n_g;
                r_s1_s    <= w_n_s;
                r_s1_nan  <= io.in_is_nan;
                r_s1_inf  <= io.in_is_inf;
                r_s1_zero <= io.in_is_zero;
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_load && r_s1_valid) begin
                r_s2_result    <= w_result;
                r_s2_overflow  <= w_overflow;
                r_s2_underflow <= w_underflow;
                r_s2_inexact   <= w_inexact;
            end
        end
    end

    assign io.out_valid     = r_s2_valid;
    assign io.out_result    = r_s2_result;
    assign io.out_overflow  = r_s2_overflow;
    assign io.out_underflow = r_s2_underflow;
    assign io.out_inexact   = r_s2_inexact;

endmodule

// File: tb/tb_fp32_mul_round_stage.sv
// Bench for fp32_mul_round_stage: directed corner cases with fixed expected values plus a
// randomized stream checked through a reference-model scoreboard under random backpressure.
module tb_fp32_mul_round_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp32_mul_round_stage_if bus();

    fp32_mul_round_stage #(
        .QNAN(32'h7FC0_0000),
        .FTZ (1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [34:0] sb_q[$];
    logic [34:0] mon_exp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: widen to a 25-bit significand and round by comparing the remainder to one half.
    function automatic logic [34:0] model(input logic s, input logic [9:0] ex, input logic [47:0] m,
                                          input logic nan, input logic inf, input logic zero);
        int          e;
        logic [47:0] n;
        logic [24:0] sig;
        logic [23:0] rem;
        if (nan)  return {32'h7FC0_0000, 3'b000};
        if (inf)  return {s, 8'hFF, 23'd0, 3'b000};
        if (zero) return {s, 31'd0, 3'b000};
        e = $signed(ex);
        if (m[47]) begin
            n = m;
            e = e + 1;
        end else begin
            n = m << 1;
        end
        sig = {2'b01, n[46:24]};
        rem = n[23:0];
        if (rem > 24'h80_0000 || (rem == 24'h80_0000 && sig[0])) sig = sig + 25'd1;
        if (sig[24]) begin
            e   = e + 1;
            sig = sig >> 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0, 3'b101};
        if (e <= 0)   return {s, 31'd0, 3'b011};
        return {s, e[7:0], sig[22:0], 2'b00, (rem != 24'd0)};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    mon_exp = sb_q.pop_front();
                    check("sb_result",
                          {29'd0, bus.out_result, bus.out_overflow, bus.out_underflow, bus.out_inexact},
                          {29'd0, mon_exp});
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb_q.push_back(model(bus.in_sign, bus.in_exp, bus.in_mant,
                                     bus.in_is_nan, bus.in_is_inf, bus.in_is_zero));
        end
    end

    task automatic set_in(input logic s, input logic [9:0] e, input logic [47:0] m,
                          input logic nan, input logic inf, input logic zero);
        bus.in_sign    = s;
        bus.in_exp     = e;
        bus.in_mant    = m;
        bus.in_is_nan  = nan;
        bus.in_is_inf  = inf;
        bus.in_is_zero = zero;
        bus.in_valid   = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the edge that transferred the item.
    task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] m,
                         input logic nan, input logic inf, input logic zero);
        set_in(s, e, m, nan, inf, zero);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        check("accept", bus.in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic s, input logic [9:0] e, input logic [47:0] m,
                            input logic nan, input logic inf, input logic zero,
                            input logic [31:0] er, input logic [2:0] ef);
        drive(s, e, m, nan, inf, zero);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, bus.out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_res"}, bus.out_result, er);
        check({tag, "_flags"}, {bus.out_overflow, bus.out_underflow, bus.out_inexact}, ef);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        set_in(0, '0, '0, 0, 0, 0);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ovalid", bus.out_valid, 0);
        check("rst_result", bus.out_result, 0);
        check("rst_flags", {bus.out_overflow, bus.out_underflow, bus.out_inexact}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_inready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        directed("t1",      0, 10'd127, 48'h9000_0000_0000, 0, 0, 0, 32'h4010_0000, 3'b000);
        directed("t2_tie",  0, 10'd127, 48'h4000_0040_0000, 0, 0, 0, 32'h3F80_0000, 3'b001);
        directed("t2_odd",  0, 10'd127, 48'h4000_00C0_0000, 0, 0, 0, 32'h3F80_0002, 3'b001);
        directed("t3",      0, 10'd127, 48'h7FFF_FFC0_0000, 0, 0, 0, 32'h4000_0000, 3'b001);
        directed("t4_ovf",  1, 10'd254, 48'h8000_0000_0000, 0, 0, 0, 32'hFF80_0000, 3'b101);
        directed("t4_unf",  0, 10'd0,   48'h4000_0000_0000, 0, 0, 0, 32'h0000_0000, 3'b011);
        directed("t5_nan",  1, 10'd127, 48'h4000_0000_0000, 1, 1, 0, 32'h7FC0_0000, 3'b000);
        directed("t5_zero", 1, 10'd127, 48'h4000_0000_0000, 0, 0, 1, 32'h8000_0000, 3'b000);
        directed("inf",     0, 10'd127, 48'h4000_0000_0000, 0, 1, 0, 32'h7F80_0000, 3'b000);
        directed("emin",    1, 10'h381, 48'h4000_0000_0000, 0, 0, 0, 32'h8000_0000, 3'b011);
        directed("emax",    0, 10'd383, 48'h8000_0000_0000, 0, 0, 0, 32'h7F80_0000, 3'b101);
        directed("rnd_ovf", 0, 10'd254, 48'h7FFF_FFC0_0000, 0, 0, 0, 32'h7F80_0000, 3'b101);
        directed("minnorm", 0, 10'd1,   48'h4000_0000_0000, 0, 0, 0, 32'h0080_0000, 3'b000);
        directed("rnd_min", 0, 10'd0,   48'h7FFF_FFC0_0000, 0, 0, 0, 32'h0080_0000, 3'b001);
        directed("maxnorm", 0, 10'd254, 48'h4000_0000_0000, 0, 0, 0, 32'h7F00_0000, 3'b000);

        // Stall: two accepts fill the pipe, then the output must hold item 1.
        bus.out_ready = 1'b0;
        drive(0, 10'd127, 48'h9000_0000_0000, 0, 0, 0);
        drive(0, 10'd127, 48'h4000_00C0_0000, 0, 0, 0);
        set_in(0, 10'd127, 48'h7FFF_FFC0_0000, 0, 0, 0);
        @(negedge clk);
        check("t6_inready", bus.in_ready, 0);
        check("t6_ovalid", bus.out_valid, 1);
        check("t6_hold", bus.out_result, 32'h4010_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_hold", bus.out_result, 32'h4010_0000);
            check("t6_inready_low", bus.in_ready, 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drive(0, 10'd127, 48'h7FFF_FFC0_0000, 0, 0, 0);
        drive(1, 10'd254, 48'h8000_0000_0000, 0, 0, 0);
        bus.in_valid = 1'b0;
        for (int t = 0; t < 20 && sb_q.size() != 0; t++) @(negedge clk);
        check("t6_drain", sb_q.size(), 0);
        @(posedge clk);
        #1;

        // Reset mid-stream: in-flight items vanish.
        bus.out_ready = 1'b0;
        drive(0, 10'd127, 48'h9000_0000_0000, 0, 0, 0);
        drive(1, 10'd130, 48'h4000_00C0_0000, 0, 0, 0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ovalid", bus.out_valid, 0);
        check("midrst_inready", bus.in_ready, 1);
        check("midrst_result", bus.out_result, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_out", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Random stream under random backpressure.
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    logic [47:0] m;
                    logic [9:0]  e;
                    int          x;
                    m = {16'($urandom), $urandom};
                    if ($urandom_range(0, 1) == 0) m[47] = 1'b1;
                    else begin
                        m[47] = 1'b0;
                        m[46] = 1'b1;
                    end
                    if ($urandom_range(0, 3) == 0) m[21:0] = '0;
                    if ($urandom_range(0, 3) == 0) x = 252 + $urandom_range(0, 4);
                    else if ($urandom_range(0, 3) == 0) x = $urandom_range(0, 3) - 2;
                    else x = $urandom_range(0, 510) - 127;
                    e = x[9:0];
                    drive(1'($urandom), e, m, ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
                    if ($urandom_range(0, 3) == 0) begin
                        bus.in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                bus.in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join

        for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(negedge clk);
        check("final_drain", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
